// File: rtl/dir_key_tracker.sv
`default_nettype none
// ============================================================================
// Module   : dir_key_tracker
// Purpose  : Decodes make/break scan bytes for four direction keys, tracks the
//            held set, reports last-pressed direction and a periodic step tick.
// Revision : 1.0 - initial release
// ============================================================================
module dir_key_tracker #(
  parameter int               N           = 8,
  parameter logic [N-1:0]     UP_CODE     = 8'h6F,
  parameter logic [N-1:0]     RIGHT_CODE  = 8'h8F,
  parameter logic [N-1:0]     DOWN_CODE   = 8'h77,
  parameter logic [N-1:0]     LEFT_CODE   = 8'hCF,
  parameter logic [N-1:0]     BREAK_CODE  = 8'hF0,
  parameter int               TICK_PERIOD = 253125,
  parameter int               CNT_W       = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data,
  input  logic         data_valid,
  output logic [2:0]   q,
  output logic [3:0]   held,
  output logic         NS,
  output logic         step
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BREAK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TICK_PERIOD - 1);

  state_t           state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic [2:0]       last_dir_q, last_dir_d;
  logic [2:0]       q_q, q_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ns_q, ns_d;

  logic [2:0]       dir_code;
  logic [3:0]       dir_onehot;

  function automatic logic [3:0] dir_to_onehot(input logic [2:0] dir);
    logic [3:0] oh;
    oh = 4'b0000;
    case (dir)
      3'd1:    oh = 4'b0001;
      3'd2:    oh = 4'b0010;
      3'd3:    oh = 4'b0100;
      3'd4:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  always_comb begin
    dir_code = 3'd0;
    if (data == UP_CODE)         dir_code = 3'd1;
    else if (data == RIGHT_CODE) dir_code = 3'd2;
    else if (data == DOWN_CODE)  dir_code = 3'd3;
    else if (data == LEFT_CODE)  dir_code = 3'd4;
    dir_onehot = dir_to_onehot(dir_code);
  end

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    last_dir_d = last_dir_q;
    q_d        = 3'd0;

    if (data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (data == BREAK_CODE) begin
            state_d = ST_BREAK;
          end else if (dir_code != 3'd0) begin
            held_d     = held_q | dir_onehot;
            last_dir_d = dir_code;
          end
        end
        default: begin
          // Any byte closes the release sequence; only direction codes clear a bit.
          state_d = ST_IDLE;
          held_d  = held_q & ~dir_onehot;
        end
      endcase
    end

    if ((held_d & dir_to_onehot(last_dir_d)) != 4'b0000) q_d = last_dir_d;
    else if (held_d[0])                                  q_d = 3'd1;
    else if (held_d[1])                                  q_d = 3'd2;
    else if (held_d[2])                                  q_d = 3'd3;
    else if (held_d[3])                                  q_d = 3'd4;

    if (held_d == 4'b0000) last_dir_d = 3'd0;
  end

  always_comb begin
    count_d = (count_q == c_cnt_last) ? '0 : count_q + 1'b1;
    ns_d    = (count_d == c_cnt_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      held_q     <= 4'b0000;
      last_dir_q <= 3'd0;
      q_q        <= 3'd0;
      count_q    <= '0;
      ns_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      last_dir_q <= last_dir_d;
      q_q        <= q_d;
      count_q    <= count_d;
      ns_q       <= ns_d;
    end
  end

  // step uses the q already registered in the tick cycle, not a pending update.
  assign q    = q_q;
  assign held = held_q;
  assign NS   = ns_q;
  assign step = ns_q & (q_q != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_dir_key_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_dir_key_tracker
// Purpose  : Directed self-checking bench for dir_key_tracker (TICK_PERIOD=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dir_key_tracker;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       data_valid;
  logic [2:0] q;
  logic [3:0] held;
  logic       NS;
  logic       step;

  int errors;
  int checks;
  int tb_cnt;
  int pulses;
  logic exp_ns;

  dir_key_tracker #(
    .N(8), .UP_CODE(8'h6F), .RIGHT_CODE(8'h8F), .DOWN_CODE(8'h77),
    .LEFT_CODE(8'hCF), .BREAK_CODE(8'hF0), .TICK_PERIOD(8), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid),
    .q(q), .held(held), .NS(NS), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-reset edges since the last reset edge; NS expected when this is 7 mod 8.
  always @(posedge clk) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= tb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one byte for exactly one posedge.
  task automatic send(input logic [7:0] b);
    data       = b;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic chk_dir(input string tag, input logic [2:0] eq, input logic [3:0] eh);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_held"}, 32'(held), 32'(eh));
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    tb_cnt     = 0;
    pulses     = 0;
    reset      = 1'b1;
    data       = 8'h00;
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_dir("reset_init", 3'd0, 4'b0000);
    chk("reset_init_ns", 32'(NS), 32'd0);
    chk("reset_init_step", 32'(step), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Press and release up
    send(8'h6F);
    chk_dir("press_up", 3'd1, 4'b0001);
    send(8'hF0);
    send(8'h6F);
    chk_dir("release_up", 3'd0, 4'b0000);

    // Last-pressed priority
    send(8'h6F);
    chk_dir("lp_up", 3'd1, 4'b0001);
    send(8'hCF);
    chk_dir("lp_left", 3'd4, 4'b1001);
    send(8'hF0);
    send(8'hCF);
    chk_dir("lp_rel_left", 3'd1, 4'b0001);
    send(8'hF0);
    send(8'h6F);
    chk_dir("lp_clear", 3'd0, 4'b0000);

    // Fixed-priority fallback
    send(8'h77);
    send(8'h8F);
    send(8'h6F);
    chk_dir("fb_three", 3'd1, 4'b0111);
    send(8'hF0);
    send(8'h6F);
    chk_dir("fb_right", 3'd2, 4'b0110);
    send(8'hF0);
    send(8'h8F);
    chk_dir("fb_down", 3'd3, 4'b0100);
    send(8'hF0);
    send(8'h77);
    chk_dir("fb_clear", 3'd0, 4'b0000);

    // Double break, then press; unknown byte ignored
    send(8'hF0);
    send(8'hF0);
    send(8'h6F);
    chk_dir("dbl_break_press", 3'd1, 4'b0001);
    send(8'h1C);
    chk_dir("unknown_byte", 3'd1, 4'b0001);

    // Back-to-back bytes with data_valid held high across them
    send(8'hCF);
    send(8'hF0);
    send(8'h6F);
    chk_dir("b2b", 3'd4, 4'b1000);
    send(8'hF0);
    send(8'hCF);
    chk_dir("b2b_clear", 3'd0, 4'b0000);

    // Pending break discarded by reset
    send(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(8'h6F);
    chk_dir("break_vs_reset", 3'd1, 4'b0001);

    // Reset mid-count with two keys held
    send(8'h8F);
    chk_dir("pre_reset", 3'd2, 4'b0011);
    reset = 1'b1;
    @(negedge clk);
    chk_dir("mid_reset", 3'd0, 4'b0000);
    chk("mid_reset_ns", 32'(NS), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("first_ns_%0d", k), 32'(NS), (k == 7) ? 32'd1 : 32'd0);
    end

    // Tick/step with right held
    send(8'h8F);
    chk_dir("tick_hold", 3'd2, 4'b0010);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      exp_ns = ((tb_cnt % 8) == 7);
      if (NS) pulses++;
      chk("tick_ns", 32'(NS), 32'(exp_ns));
      chk("tick_step", 32'(step), 32'(exp_ns));
    end
    chk("tick_pulses", 32'(pulses), 32'd3);
    send(8'hF0);
    send(8'h8F);
    chk_dir("tick_release", 3'd0, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_ns = ((tb_cnt % 8) == 7);
      chk("idle_ns", 32'(NS), 32'(exp_ns));
      chk("idle_step", 32'(step), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
